// File: rtl/mprj_wb_arbiter.sv
// rtl/mprj_wb_arbiter.sv - two-master Wishbone classic arbiter with round-robin grant and transfer timeout
module mprj_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic        timeout_o,
    input  logic        timeout_clr_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter value at which a transfer with no ack is forcibly terminated
    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic [15:0] r_cnt;
    logic        r_timeout;

    logic        w_req0;
    logic        w_req1;
    logic        w_busy;
    logic        w_owner1;
    logic        w_own_cyc;
    logic        w_tmo_hit;
    logic        w_exit;

    assign w_req0    = m0_cyc_i & m0_stb_i;
    assign w_req1    = m1_cyc_i & m1_stb_i;
    assign w_busy    = (r_state == BUSY0) || (r_state == BUSY1);
    assign w_owner1  = (r_state == BUSY1);
    assign w_own_cyc = w_owner1 ? m1_cyc_i : m0_cyc_i;
    // Ack beats abort, abort beats timeout: an aborting master never receives a synthetic ack
    assign w_tmo_hit = w_busy && !s_ack_i && w_own_cyc && (r_cnt == LP_TMO_LAST);
    assign w_exit    = w_busy && (s_ack_i || !w_own_cyc || w_tmo_hit);
    assign timeout_o = r_timeout;

    // State, round-robin pointer, wait counter and sticky timeout flag
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_cnt     <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_exit) begin
                r_last <= w_owner1;
            end
            r_cnt <= (w_busy && !w_exit) ? r_cnt + 16'd1 : 16'd0;
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end else if (timeout_clr_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Next-state selection and the routing of the owning master to the shared target
    always_comb begin
        w_next   = r_state;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'd0;
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        m0_ack_o = 1'b0;
        m0_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_dat_o = 32'd0;
        grant_o  = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next = r_last ? BUSY0 : BUSY1;
                end else if (w_req0) begin
                    w_next = BUSY0;
                end else if (w_req1) begin
                    w_next = BUSY1;
                end
            end
            BUSY0: begin
                if (w_exit) begin
                    w_next = DONE;
                end
                grant_o  = 2'b01;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i | w_tmo_hit;
                m0_dat_o = w_tmo_hit ? 32'hFFFF_FFFF : s_dat_i;
            end
            BUSY1: begin
                if (w_exit) begin
                    w_next = DONE;
                end
                grant_o  = 2'b10;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i | w_tmo_hit;
                m1_dat_o = w_tmo_hit ? 32'hFFFF_FFFF : s_dat_i;
            end
            DONE: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mprj_wb_arbiter.md
MPRJ_WB_ARBITER -- requirements
Module: mprj_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a granted transfer waits for s_ack_i (range 1..65535).
REQ-002 SHALL have one clock, wb_clk_i: input, 1 bit, rising-edge clock for all state.
REQ-003 SHALL have wb_rst_i: input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have, for N = 0 and 1, mN_cyc_i, mN_stb_i and mN_we_i: input, 1 bit each, Wishbone classic master N cycle, strobe and write-enable. Master 0 is the management SoC; master 1 is the core debug bus.
REQ-005 SHALL have mN_sel_i: input, 4 bits, master N byte selects.
REQ-006 SHALL have mN_adr_i and mN_dat_i: input, 32 bits each, master N address and write data.
REQ-007 SHALL have mN_ack_o: output, 1 bit, master N acknowledge.
REQ-008 SHALL have mN_dat_o: output, 32 bits, master N read data.
REQ-009 SHALL have s_cyc_o, s_stb_o and s_we_o: output, 1 bit each, shared target cycle, strobe and write-enable.
REQ-010 SHALL have s_sel_o: output, 4 bits, target byte selects.
REQ-011 SHALL have s_adr_o and s_dat_o: output, 32 bits each, target address and write data.
REQ-012 SHALL have s_ack_i: input, 1 bit, target acknowledge.
REQ-013 SHALL have s_dat_i: input, 32 bits, target read data.
REQ-014 SHALL have timeout_o: output, 1 bit, sticky timeout flag.
REQ-015 SHALL have timeout_clr_i: input, 1 bit, clears timeout_o.
REQ-016 SHALL have grant_o: output, 2 bits, one-hot current owner (bit N = master N); 00 when idle.

Function
REQ-017 SHALL implement an FSM with states IDLE, BUSY0, BUSY1 and DONE.
REQ-018 A request from master N SHALL be mN_cyc_i & mN_stb_i.
REQ-019 In IDLE, if exactly one master requests, the FSM SHALL enter BUSYn for that master on the next edge.
REQ-020 In IDLE, if both masters request, the FSM SHALL grant the master not granted last (round-robin pointer). The pointer SHALL reset to "last = 1", so master 0 wins the first contention.
REQ-021 Grant latency SHALL be exactly 1 cycle: a request first seen in cycle N drives s_cyc_o and s_stb_o high in cycle N+1.
REQ-022 In BUSYn, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL follow master n combinationally.
REQ-023 In every state other than BUSYn, all s_* outputs SHALL be 0.
REQ-024 In BUSYn, mn_ack_o SHALL equal s_ack_i and mn_dat_o SHALL equal s_dat_i, combinationally (0 added latency).
REQ-025 The ungranted master SHALL always see ack = 0 and dat_o = 0.
REQ-026 On s_ack_i in BUSYn, the FSM SHALL go to DONE, record n as last-granted, and clear the timeout counter.
REQ-027 DONE SHALL last exactly 1 cycle with all s_* outputs at 0, then go to IDLE. Back-to-back transfers are therefore at least 3 cycles apart.
REQ-028 In BUSYn, if mn_cyc_i drops before ack (abort), the FSM SHALL go to DONE next edge. No ack is issued and the pointer is updated.
REQ-029 The 16-bit timeout counter SHALL increment each BUSY cycle without s_ack_i. When it reaches TIMEOUT-1 without ack, the arbiter SHALL in that cycle assert mn_ack_o = 1 with mn_dat_o = 32'hFFFF_FFFF, set timeout_o, and go to DONE.
REQ-030 timeout_o SHALL remain set until timeout_clr_i. If set and clear coincide, set wins.
REQ-031 The counter SHALL hold 0 outside BUSY.
REQ-032 s_ack_i outside BUSY SHALL be ignored.

Reset
REQ-033 While wb_rst_i is high at an edge, the next state SHALL be: FSM = IDLE, pointer = last-granted 1, counter = 0, timeout_o = 0. From then, grant_o = 00, all s_* = 0, and all mN_ack_o and mN_dat_o = 0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer without an ack to the master. Outputs SHALL be at reset values one edge after reset is sampled.

Verification
REQ-035 Single master: m0 read of adr 0x30000004, target acks in cycle 3 with 0x12345678 -> s_cyc_o rises in cycle 1; m0_ack_o = 1 and m0_dat_o = 0x12345678 in cycle 3; m1_ack_o = 0 throughout.
REQ-036 Contention: m0 and m1 request in the same cycle from reset, target acks in 1 cycle -> grant order m0, m1, m0, m1 over 4 transfers; each grant_o pulse is separated by IDLE/DONE.
REQ-037 Timeout: TIMEOUT = 8, m1 write, target never acks -> m1_ack_o = 1 with m1_dat_o = 0xFFFFFFFF on the 8th BUSY cycle; timeout_o = 1 afterwards until a timeout_clr_i pulse.
REQ-038 Abort: m1 drops cyc 2 cycles into BUSY1 -> s_cyc_o = 0 the next cycle, no m1_ack_o, and a pending m0 request is granted afterwards.
REQ-039 Reset mid-transfer: wb_rst_i pulsed during BUSY0 -> grant_o = 00, s_cyc_o = 0 and timeout_o = 0 next cycle; a subsequent contention grants m0 first.
REQ-040 Simultaneous set/clear: timeout fires in the same cycle as timeout_clr_i = 1 -> timeout_o = 1 afterwards.
